logic_stream_reducer: RTL and testbench
=======================================

LOGIC_STREAM_REDUCER -- requirements
Module: logic_stream_reducer

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits (1..64).
REQ-002 The block SHALL have parameter MAX_BEATS, default 16: maximum beats per frame (2..256).
REQ-003 The block SHALL define CW = $clog2(MAX_BEATS+1) as the beat-count width.

Ports:
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: input beat present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block accepts a beat.
REQ-008 The block SHALL have port in_data, input, WIDTH bits: operand.
REQ-009 The block SHALL have port in_last, input, 1 bit: final beat of frame.
REQ-010 The block SHALL have port op, input, 2 bits: 00 OR, 01 AND, 10 XOR, 11 NOR; sampled on first beat only.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-013 The block SHALL have port out_data, output, WIDTH bits: reduced result.
REQ-014 The block SHALL have port out_count, output, CW bits: beats in the frame.
REQ-015 The block SHALL have port out_overflow, output, 1 bit: frame closed by the MAX_BEATS limit, not by in_last.

Function
REQ-016 A beat SHALL be accepted iff in_valid && in_ready at a rising clk edge; a result SHALL be consumed iff out_valid && out_ready.
REQ-017 The FSM SHALL have states IDLE, ACCUM, HOLD; in_ready = (state != HOLD); out_valid = (state == HOLD).
REQ-018 In IDLE, an accepted beat SHALL load acc <= in_data, latch op, set count <= 1, and go to ACCUM, or to HOLD if in_last is set.
REQ-019 In ACCUM, an accepted beat SHALL set acc <= acc OR/AND/XOR in_data (NOR mode uses OR) and count <= count+1.
REQ-020 ACCUM SHALL go to HOLD on an accepted beat with in_last, or when that beat makes count == MAX_BEATS, in which case out_overflow SHALL be set to !in_last.
REQ-021 The result SHALL appear with out_valid one cycle after the closing beat is accepted; single-beat frames SHALL have the same latency.
REQ-022 In HOLD, out_data SHALL be acc, or ~acc in NOR mode, and out_data, out_count and out_overflow SHALL stay stable until consumed.
REQ-023 Consumption in HOLD SHALL return to IDLE and clear out_overflow; the next beat is accepted no earlier than the following cycle (one bubble).
REQ-024 Changes on op after the first beat SHALL be ignored for that frame; beats after an overflow close SHALL start a new frame.
REQ-025 in_valid low SHALL stall ACCUM indefinitely with no state change.

Reset
REQ-026 With rst high at an edge: state = IDLE, acc = 0, count = 0, latched op = OR, out_overflow = 0; hence out_valid = 0, in_ready = 1, out_data = 0, out_count = 0.
REQ-027 rst SHALL take priority over any handshake in the same cycle; reset mid-frame or in HOLD SHALL discard the partial or pending result.

Structure
REQ-028 A shared package logic_stream_pkg SHALL hold the op encoding enum (OP_OR, OP_AND, OP_XOR, OP_NOR) and the FSM state enum.
REQ-029 One combinational sub-module, logic_op_unit (a, b, op -> y, WIDTH-parametrised), SHALL implement the per-beat operation and be reusable elsewhere.
REQ-030 Only acc, count, op, state and overflow SHALL be registered; outputs SHALL be driven from registers plus the NOR inversion.

Verification (WIDTH=8, MAX_BEATS=4)
REQ-031 OR frame 0x01, 0x02, 0x80 (last) -> out_data 0x83, out_count 3, out_overflow 0, out_valid one cycle after the last beat.
REQ-032 AND frame 0xF0, 0x3C (last) with op switched to XOR on beat 2 -> out_data 0x30.
REQ-033 NOR single beat 0x0F with last -> out_data 0xF0, out_count 1.
REQ-034 XOR 5 beats 0x01, 0x02, 0x04, 0x08 (no last), then 0x10 last -> first result 0x0F, count 4, overflow 1; second result 0x10, count 1, overflow 0.
REQ-035 Hold out_ready low 10 cycles in HOLD -> outputs stable, in_ready 0, beats not accepted; random in_valid gaps -> same results as gap-free input.
REQ-036 Assert rst after 2 beats of a frame -> next cycle out_valid 0, in_ready 1; new frame 0x55 last -> 0x55, count 1.

Source files
------------

// File: rtl/logic_stream_pkg.sv
// Shared encodings for the logic stream reducer: per-beat operation and control FSM states.
// Combinational helpers only; no latency or flow control lives here.
package logic_stream_pkg;

    typedef enum logic [1:0] {
        OP_OR  = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        HOLD  = 2'b10
    } state_e;

    // NOR accumulates as OR and is inverted only when the result is presented.
    function automatic logic op_inverts(input op_e op);
        return (op == OP_NOR);
    endfunction

endpackage

// File: rtl/logic_op_unit.sv
// Bitwise combine of two operands (OR/AND/XOR, NOR treated as OR); purely combinational.
// Zero latency, no flow control.
module logic_op_unit
    import logic_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a | b;
        case (op)
            OP_AND:  y = a & b;
            OP_XOR:  y = a ^ b;
            default: y = a | b;
        endcase
    end

endmodule

// File: rtl/logic_stream_reducer.sv
// Reduces a frame of beats with OR/AND/XOR/NOR; result valid one cycle after the closing beat.
// Input stalls (in_ready low) while a result waits in HOLD; one bubble cycle after consumption.
module logic_stream_reducer
    import logic_stream_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16,
    parameter int CW        = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_count,
    output logic             out_overflow
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    op_e              op_q, op_d;
    logic             ovf_q, ovf_d;

    logic             in_fire;
    logic             out_fire;
    logic [CW-1:0]    count_inc;
    logic [WIDTH-1:0] comb_y;

    logic_op_unit #(
        .WIDTH (WIDTH)
    ) u_op (
        .a  (acc_q),
        .b  (in_data),
        .op (op_q),
        .y  (comb_y)
    );

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign count_inc = count_q + CW'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        op_d    = op_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                // The first beat seeds the accumulator directly and fixes the op for the frame.
                if (in_fire) begin
                    acc_d   = in_data;
                    op_d    = op_e'(op);
                    count_d = CW'(1);
                    ovf_d   = 1'b0;
                    state_d = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (in_fire) begin
                    acc_d   = comb_y;
                    count_d = count_inc;
                    if (in_last) begin
                        ovf_d   = 1'b0;
                        state_d = HOLD;
                    end else if (count_inc == MAX_CNT) begin
                        ovf_d   = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_fire) begin
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            op_q    <= OP_OR;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            op_q    <= op_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_data     = op_inverts(op_q) ? ~acc_q : acc_q;
    assign out_count    = count_q;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_logic_stream_reducer.sv
// Directed self-checking bench for logic_stream_reducer at WIDTH=8, MAX_BEATS=4.
module tb_logic_stream_reducer;

    localparam int WIDTH     = 8;
    localparam int MAX_BEATS = 4;
    localparam int CW        = $clog2(MAX_BEATS + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_count;
    logic             out_overflow;

    int checks = 0;
    int errors = 0;

    logic_stream_reducer #(
        .WIDTH     (WIDTH),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .op           (op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one beat and returns 1 time unit after the edge that accepted it.
    task automatic send(input logic [7:0] d, input logic l, input logic [1:0] o, input string tag);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        op       = o;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic recv(input logic [7:0] d, input logic [CW-1:0] c, input logic v, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_vld"},  32'(out_valid),    32'd1);
        chk({tag, "_data"}, 32'(out_data),     32'(d));
        chk({tag, "_cnt"},  32'(out_count),    32'(c));
        chk({tag, "_ovf"},  32'(out_overflow), 32'(v));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_gone"}, 32'(out_valid), 32'd0);
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        op        = 2'b00;
        out_ready = 1'b0;
        idle(2);
        rst = 1'b0;

        chk("rst_vld",  32'(out_valid),    32'd0);
        chk("rst_rdy",  32'(in_ready),     32'd1);
        chk("rst_data", 32'(out_data),     32'd0);
        chk("rst_cnt",  32'(out_count),    32'd0);
        chk("rst_ovf",  32'(out_overflow), 32'd0);

        // Reset wins over an offered beat in the same cycle.
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b1; op = 2'b01;
        idle(1);
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("rstprio_vld", 32'(out_valid), 32'd0);
        chk("rstprio_cnt", 32'(out_count), 32'd0);

        // OR frame, result visible right after the closing edge.
        send(8'h01, 1'b0, 2'b00, "or_b1");
        send(8'h02, 1'b0, 2'b00, "or_b2");
        chk("or_not_yet", 32'(out_valid), 32'd0);
        send(8'h80, 1'b1, 2'b00, "or_b3");
        chk("or_latency", 32'(out_valid), 32'd1);
        recv(8'h83, 3'd3, 1'b0, "or");

        // AND frame; op switched to XOR on beat 2 must be ignored.
        send(8'hF0, 1'b0, 2'b01, "and_b1");
        send(8'h3C, 1'b1, 2'b10, "and_b2");
        recv(8'h30, 3'd2, 1'b0, "and");

        // NOR single beat, same latency.
        send(8'h0F, 1'b1, 2'b11, "nor_b1");
        chk("nor_latency", 32'(out_valid), 32'd1);
        recv(8'hF0, 3'd1, 1'b0, "nor");

        // XOR overflow close, then the trailing beat forms its own frame.
        send(8'h01, 1'b0, 2'b10, "xor_b1");
        send(8'h02, 1'b0, 2'b10, "xor_b2");
        send(8'h04, 1'b0, 2'b10, "xor_b3");
        send(8'h08, 1'b0, 2'b10, "xor_b4");
        chk("xor_ovf_close", 32'(out_valid), 32'd1);
        recv(8'h0F, 3'd4, 1'b1, "xor1");
        send(8'h10, 1'b1, 2'b10, "xor_b5");
        recv(8'h10, 3'd1, 1'b0, "xor2");

        // OR frame with random idle gaps, including a long ACCUM stall.
        idle($urandom_range(0, 3));
        send(8'h01, 1'b0, 2'b00, "gap_b1");
        idle(5);
        chk("stall_rdy", 32'(in_ready),  32'd1);
        chk("stall_vld", 32'(out_valid), 32'd0);
        idle($urandom_range(0, 3));
        send(8'h02, 1'b0, 2'b11, "gap_b2");
        idle($urandom_range(0, 3));
        send(8'h80, 1'b1, 2'b01, "gap_b3");
        recv(8'h83, 3'd3, 1'b0, "gap");

        // Back-pressure in HOLD: outputs frozen, offered beat refused.
        send(8'h3C, 1'b1, 2'b01, "hold_b1");
        in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1; op = 2'b00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_vld",  32'(out_valid), 32'd1);
            chk("hold_rdy",  32'(in_ready),  32'd0);
            chk("hold_data", 32'(out_data),  32'h3C);
            chk("hold_cnt",  32'(out_count), 32'd1);
        end
        // Consume while a beat is offered: one bubble, then the beat is taken.
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        chk("bubble_vld", 32'(out_valid), 32'd0);
        chk("bubble_rdy", 32'(in_ready),  32'd1);
        idle(1);
        in_valid = 1'b0; in_last = 1'b0;
        recv(8'hFF, 3'd1, 1'b0, "after_bubble");

        // Reset mid-frame discards the partial result.
        send(8'h11, 1'b0, 2'b00, "mid_b1");
        send(8'h22, 1'b0, 2'b00, "mid_b2");
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("midrst_vld", 32'(out_valid), 32'd0);
        chk("midrst_rdy", 32'(in_ready),  32'd1);
        chk("midrst_cnt", 32'(out_count), 32'd0);
        send(8'h55, 1'b1, 2'b00, "new_b1");
        recv(8'h55, 3'd1, 1'b0, "new");

        // Reset in HOLD discards the pending result.
        send(8'h77, 1'b1, 2'b11, "hrst_b1");
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("holdrst_vld",  32'(out_valid), 32'd0);
        chk("holdrst_data", 32'(out_data),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
